// File: rtl/confreg_responder_pkg.sv
// Shared definitions for the confreg responder: address window, register
// word offsets, interrupt status bit positions and the byte-lane merge helper.
// No ports; imported by confreg_responder and its sub-module.
package confreg_responder_pkg;

  // Upper address half that selects the register window.
  localparam logic [15:0] CONFREG_BASE_HI = 16'hBFAF;

  // Word offsets (byte offset >> 2), compared against addr[15:2].
  localparam logic [13:0] OFF_LED    = 14'h0000; // 0x00
  localparam logic [13:0] OFF_SW     = 14'h0001; // 0x04
  localparam logic [13:0] OFF_TIMER  = 14'h0002; // 0x08
  localparam logic [13:0] OFF_CMP    = 14'h0003; // 0x0C
  localparam logic [13:0] OFF_INTST  = 14'h0004; // 0x10
  localparam logic [13:0] OFF_TXDATA = 14'h0005; // 0x14
  localparam logic [13:0] OFF_TXST   = 14'h0006; // 0x18

  // INT_STATUS bit positions.
  localparam int INT_PEND_BIT = 0;
  localparam int INT_OVF_BIT  = 1;

  // Replace only the byte lanes whose enable is set.
  function automatic logic [31:0] byte_merge(input logic [31:0] old_val,
                                             input logic [31:0] new_val,
                                             input logic [3:0]  be);
    logic [31:0] res;
    res = old_val;
    for (int i = 0; i < 4; i++) begin
      if (be[i]) res[i*8 +: 8] = new_val[i*8 +: 8];
    end
    return res;
  endfunction

endpackage

// File: rtl/confreg_responder_sync_fifo.sv
// Synchronous circular-buffer FIFO with one extra pointer bit to tell full
// from empty. Ports: push/din write side, pop read side, full/empty/count
// status, head = current oldest entry (0 when empty).
module sync_fifo #(
  parameter  int WIDTH = 8,
  parameter  int DEPTH = 4,
  localparam int AW    = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             push,
  input  logic [WIDTH-1:0] din,
  input  logic             pop,
  output logic             full,
  output logic             empty,
  output logic [AW:0]      count,
  output logic [WIDTH-1:0] head
);

  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW:0]      wptr;
  logic [AW:0]      rptr;
  logic             do_push;
  logic             do_pop;

  assign empty = (wptr == rptr);
  assign full  = (wptr[AW] != rptr[AW]) && (wptr[AW-1:0] == rptr[AW-1:0]);
  assign count = wptr - rptr;
  // Masked when empty so the output is a clean 0 after reset.
  assign head  = empty ? '0 : mem[rptr[AW-1:0]];

  assign do_pop  = pop && !empty;
  // A pop in the same cycle frees the slot, so a push into a full FIFO is kept.
  assign do_push = push && (!full || do_pop);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      wptr <= '0;
      rptr <= '0;
    end else begin
      if (do_push) wptr <= wptr + PTR_ONE;
      if (do_pop)  rptr <= rptr + PTR_ONE;
    end
  end

  // Storage carries no reset; pointers alone define which entries are live.
  always_ff @(posedge clk) begin
    if (do_push && !reset) mem[wptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/confreg_responder.sv
// Memory-mapped peripheral responder: LEDs, synchronized switches, timer with
// compare interrupt, and a byte TX FIFO drained by a valid/ready stream.
// Ports: memen/wea/addr/wdata/rdata CPU data port; sw_i, led_o, irq_o; tx_valid/tx_data/tx_ready.
module confreg_responder
  import confreg_responder_pkg::*;
#(
  parameter logic [15:0] BASE_HI    = CONFREG_BASE_HI,
  parameter int          LED_W      = 16,
  parameter int          SW_W       = 8,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             memen,
  input  logic [3:0]       wea,
  input  logic [31:0]      addr,
  input  logic [31:0]      wdata,
  output logic [31:0]      rdata,
  input  logic [SW_W-1:0]  sw_i,
  output logic [LED_W-1:0] led_o,
  output logic             irq_o,
  output logic             tx_valid,
  output logic [7:0]       tx_data,
  input  logic             tx_ready
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  // Decode
  logic        sel;
  logic        wr;
  logic        rd;
  logic [13:0] offset;
  logic        unused_addr_lsb;

  assign sel    = memen && (addr[31:16] == BASE_HI);
  assign offset = addr[15:2];
  assign wr     = sel && (|wea);
  assign rd     = sel && (wea == 4'b0000);
  assign unused_addr_lsb = ^addr[1:0];

  logic wr_led, wr_timer, wr_cmp, wr_intst, wr_txd;
  assign wr_led   = wr && (offset == OFF_LED);
  assign wr_timer = wr && (offset == OFF_TIMER);
  assign wr_cmp   = wr && (offset == OFF_CMP);
  assign wr_intst = wr && (offset == OFF_INTST);
  assign wr_txd   = wr && (offset == OFF_TXDATA);

  // State
  logic [LED_W-1:0] led;
  logic [SW_W-1:0]  sw_meta;
  logic [SW_W-1:0]  sw_sync;
  logic [31:0]      timer;
  logic [31:0]      compare;
  logic             pend;
  logic             ovf;

  // Byte-merged write values
  logic [31:0] led_merged;
  logic [31:0] timer_merged;
  logic [31:0] cmp_merged;
  logic [31:0] timer_inc;

  always_comb begin
    led_merged   = byte_merge(32'(led), wdata, wea);
    timer_merged = byte_merge(timer, wdata, wea);
    cmp_merged   = byte_merge(compare, wdata, wea);
  end

  assign timer_inc = timer + 32'd1;

  // TX FIFO
  logic          tx_full;
  logic          tx_empty;
  logic [CW-1:0] tx_count;
  logic          tx_pop;
  logic          tx_push;
  logic          ovf_set;
  logic          pend_set;

  assign tx_valid = !tx_empty;
  assign tx_pop   = tx_valid && tx_ready;
  assign tx_push  = wr_txd && wea[0];
  // Dropped only when there is no room and nothing leaves this cycle.
  assign ovf_set  = tx_push && tx_full && !tx_pop;
  assign pend_set = (timer_inc == compare);

  sync_fifo #(
    .WIDTH (8),
    .DEPTH (FIFO_DEPTH)
  ) u_tx_fifo (
    .clk   (clk),
    .reset (reset),
    .push  (tx_push),
    .din   (wdata[7:0]),
    .pop   (tx_pop),
    .full  (tx_full),
    .empty (tx_empty),
    .count (tx_count),
    .head  (tx_data)
  );

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      led     <= '0;
      sw_meta <= '0;
      sw_sync <= '0;
      timer   <= '0;
      compare <= 32'hFFFF_FFFF;
      pend    <= 1'b0;
      ovf     <= 1'b0;
    end else begin
      sw_meta <= sw_i;
      sw_sync <= sw_meta;

      if (wr_led) led <= led_merged[LED_W-1:0];

      // A software write to TIMER takes the place of the increment.
      if (wr_timer) timer <= timer_merged;
      else          timer <= timer_inc;

      if (wr_cmp) compare <= cmp_merged;

      // Priority: COMPARE write clears > match sets > W1C clears.
      if (wr_cmp)                                   pend <= 1'b0;
      else if (pend_set)                            pend <= 1'b1;
      else if (wr_intst && wdata[INT_PEND_BIT])     pend <= 1'b0;

      if (ovf_set)                                  ovf <= 1'b1;
      else if (wr_intst && wdata[INT_OVF_BIT])      ovf <= 1'b0;
    end
  end

  assign led_o = led;
  assign irq_o = pend;

  // Read mux, combinational and side-effect free
  always_comb begin
    rdata = '0;
    if (rd) begin
      case (offset)
        OFF_LED:   rdata = 32'(led);
        OFF_SW:    rdata = 32'(sw_sync);
        OFF_TIMER: rdata = timer;
        OFF_CMP:   rdata = compare;
        OFF_INTST: begin
          rdata[INT_PEND_BIT] = pend;
          rdata[INT_OVF_BIT]  = ovf;
        end
        OFF_TXST:  rdata = {22'd0, tx_empty, tx_full, 8'(tx_count)};
        default:   rdata = '0;
      endcase
    end
  end

endmodule

// File: tb/tb_confreg_responder.sv
// Directed bench for confreg_responder: LED merge, timer wrap/compare IRQ,
// TX FIFO fill/overflow/drain, decode misses, switch sync, async reset.
module tb_confreg_responder;

  logic        clk = 1'b0;
  logic        reset;
  logic        memen;
  logic [3:0]  wea;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata;
  logic [7:0]  sw_i;
  logic [15:0] led_o;
  logic        irq_o;
  logic        tx_valid;
  logic [7:0]  tx_data;
  logic        tx_ready;

  int errors = 0;
  int checks = 0;

  localparam logic [31:0] A_LED   = 32'hBFAF_0000;
  localparam logic [31:0] A_SW    = 32'hBFAF_0004;
  localparam logic [31:0] A_TIMER = 32'hBFAF_0008;
  localparam logic [31:0] A_CMP   = 32'hBFAF_000C;
  localparam logic [31:0] A_INTST = 32'hBFAF_0010;
  localparam logic [31:0] A_TXD   = 32'hBFAF_0014;
  localparam logic [31:0] A_TXST  = 32'hBFAF_0018;

  confreg_responder dut (
    .clk      (clk),
    .reset    (reset),
    .memen    (memen),
    .wea      (wea),
    .addr     (addr),
    .wdata    (wdata),
    .rdata    (rdata),
    .sw_i     (sw_i),
    .led_o    (led_o),
    .irq_o    (irq_o),
    .tx_valid (tx_valid),
    .tx_data  (tx_data),
    .tx_ready (tx_ready)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic bus_wr(input logic [31:0] a, input logic [31:0] d, input logic [3:0] be);
    memen = 1'b1; wea = be; addr = a; wdata = d;
    tick();
    memen = 1'b0; wea = 4'b0000; wdata = '0;
  endtask

  task automatic rd_chk(input string tag, input logic [31:0] a, input logic [31:0] exp);
    memen = 1'b1; wea = 4'b0000; addr = a;
    #1;
    check(tag, rdata, exp);
    memen = 1'b0;
  endtask

  initial begin
    reset = 1'b1; memen = 1'b0; wea = '0; addr = '0; wdata = '0;
    sw_i = '0; tx_ready = 1'b0;
    tick(); tick();
    check("rst_rdata", rdata, 32'h0);
    check("rst_irq", 32'(irq_o), 32'h0);
    check("rst_txvalid", 32'(tx_valid), 32'h0);
    check("rst_txdata", 32'(tx_data), 32'h0);
    check("rst_led", 32'(led_o), 32'h0);
    reset = 1'b0;
    tick();

    // LED byte-lane merge
    bus_wr(A_LED, 32'h0000_FFFF, 4'b1111);
    check("led_ffff", 32'(led_o), 32'h0000_FFFF);
    bus_wr(A_LED, 32'h1234_ABCD, 4'b0011);
    check("led_abcd", 32'(led_o), 32'h0000_ABCD);
    bus_wr(A_LED, 32'h0000_0000, 4'b0100);
    check("led_lane2", 32'(led_o), 32'h0000_ABCD);
    rd_chk("led_read", A_LED, 32'h0000_ABCD);
    rd_chk("led_read_lsb", A_LED | 32'h3, 32'h0000_ABCD);

    // Timer wrap and compare interrupt
    bus_wr(A_TIMER, 32'hFFFF_FFFD, 4'b1111);
    bus_wr(A_CMP, 32'h0000_0001, 4'b1111);
    rd_chk("timer_fffe", A_TIMER, 32'hFFFF_FFFE);
    rd_chk("cmp_read", A_CMP, 32'h0000_0001);
    check("irq_pre", 32'(irq_o), 32'h0);
    tick();
    check("irq_at_ffff", 32'(irq_o), 32'h0);
    tick();
    rd_chk("timer_wrap0", A_TIMER, 32'h0);
    check("irq_at_0", 32'(irq_o), 32'h0);
    tick();
    check("irq_rise", 32'(irq_o), 32'h1);
    rd_chk("intst_pend", A_INTST, 32'h1);
    bus_wr(A_INTST, 32'h1, 4'b0001);
    check("irq_w1c", 32'(irq_o), 32'h0);
    // timer now 2: arm compare=4, then overwrite it on the matching edge
    bus_wr(A_CMP, 32'h4, 4'b1111);
    bus_wr(A_CMP, 32'h100, 4'b1111);
    check("irq_cmp_wins", 32'(irq_o), 32'h0);
    tick(); tick();
    rd_chk("intst_cmp_wins", A_INTST, 32'h0);

    // TX FIFO fill and overflow
    bus_wr(A_TXD, 32'h11, 4'b0001);
    bus_wr(A_TXD, 32'h22, 4'b0001);
    bus_wr(A_TXD, 32'h33, 4'b0001);
    bus_wr(A_TXD, 32'h44, 4'b0001);
    rd_chk("txst_full", A_TXST, 32'h104);
    check("txvalid_full", 32'(tx_valid), 32'h1);
    check("txdata_head", 32'(tx_data), 32'h11);
    rd_chk("txdata_reads0", A_TXD, 32'h0);
    bus_wr(A_TXD, 32'h55, 4'b0001);
    rd_chk("intst_ovf", A_INTST, 32'h2);
    rd_chk("txst_after_drop", A_TXST, 32'h104);
    check("txdata_stable", 32'(tx_data), 32'h11);

    // Push and pop together on a full FIFO
    tx_ready = 1'b1;
    bus_wr(A_TXD, 32'h66, 4'b0001);
    tx_ready = 1'b0;
    rd_chk("txst_pushpop", A_TXST, 32'h104);
    check("txdata_after_pop", 32'(tx_data), 32'h22);
    rd_chk("intst_ovf_keep", A_INTST, 32'h2);

    // Drain
    tx_ready = 1'b1;
    check("drain0", 32'(tx_data), 32'h22); tick();
    check("drain1", 32'(tx_data), 32'h33); tick();
    check("drain2", 32'(tx_data), 32'h44); tick();
    check("drain3", 32'(tx_data), 32'h66); tick();
    tx_ready = 1'b0;
    check("drain_empty", 32'(tx_valid), 32'h0);
    rd_chk("txst_empty", A_TXST, 32'h200);
    bus_wr(A_INTST, 32'h2, 4'b0001);
    rd_chk("intst_ovf_clr", A_INTST, 32'h0);

    // Decode misses
    bus_wr(32'hBFAE_0000, 32'h0, 4'b1111);
    check("miss_wr_led", 32'(led_o), 32'h0000_ABCD);
    rd_chk("miss_rd", 32'hBFAE_0000, 32'h0);
    rd_chk("unmapped_1c", 32'hBFAF_001C, 32'h0);
    bus_wr(32'hBFAF_001C, 32'hFFFF_FFFF, 4'b1111);
    check("unmapped_wr_led", 32'(led_o), 32'h0000_ABCD);
    rd_chk("txst_unchanged", A_TXST, 32'h200);
    addr = A_LED; memen = 1'b0; #1;
    check("rdata_no_memen", rdata, 32'h0);

    // Switch synchronizer: two-edge latency
    rd_chk("sw_init", A_SW, 32'h0);
    sw_i = 8'hA5;
    tick();
    rd_chk("sw_1cyc", A_SW, 32'h0);
    tick();
    rd_chk("sw_2cyc", A_SW, 32'h0000_00A5);

    // Reset with FIFO holding 2 bytes and pend set
    bus_wr(A_TIMER, 32'h10, 4'b1111);
    bus_wr(A_CMP, 32'h12, 4'b1111);
    tick();
    bus_wr(A_TXD, 32'h77, 4'b0001);
    bus_wr(A_TXD, 32'h88, 4'b0001);
    check("pre_rst_irq", 32'(irq_o), 32'h1);
    rd_chk("pre_rst_txst", A_TXST, 32'h202 & 32'h002);
    #1;
    reset = 1'b1;
    #1;
    check("midrst_irq", 32'(irq_o), 32'h0);
    check("midrst_txvalid", 32'(tx_valid), 32'h0);
    check("midrst_txdata", 32'(tx_data), 32'h0);
    check("midrst_led", 32'(led_o), 32'h0);
    rd_chk("midrst_txst", A_TXST, 32'h200);
    rd_chk("midrst_cmp", A_CMP, 32'hFFFF_FFFF);
    memen = 1'b0; #1;
    check("midrst_rdata", rdata, 32'h0);
    tick();
    reset = 1'b0;
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
